// File: rtl/rst_sequencer.sv
// Reset sequencer: merges power-on, pushbutton, software and watchdog causes, holds all stages in
// reset, then releases them in order. The watchdog is built only when RST_SEQ_WDOG_EN is defined.
module rst_sequencer #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned BTN_FILT    = 8,
    parameter int unsigned WDOG_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_n,
    input  logic                  sw_rst_req,
    input  logic                  wdog_kick,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic [1:0]            rst_cause
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GapW  = $clog2(STAGE_GAP + 1);
    localparam int unsigned FiltW = $clog2(BTN_FILT + 1);

    typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

    state_e                state_q, state_d;
    logic                  btn_s1, btn_s2;
    logic [FiltW-1:0]      filt_cnt;
    logic                  btn_q;
    logic                  wdog_exp;
    logic                  req;
    logic [1:0]            req_cause;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d, stage_shift;
    logic                  done_q, done_d;
    logic [1:0]            cause_q, cause_d;
    logic                  hold_last, gap_last;

    // Button: 2-flop synchronizer, then a saturating count of consecutive low samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b1;
            btn_s2   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            if (btn_s2) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FiltW'(BTN_FILT)) begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign btn_q = (filt_cnt == FiltW'(BTN_FILT));

`ifdef RST_SEQ_WDOG_EN
    logic [WDOG_BITS-1:0] wdog_cnt;

    assign wdog_exp = &wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if ((state_q != StRun) || wdog_kick || wdog_exp) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    logic [WDOG_BITS-1:0] unused_wdog;

    assign unused_wdog = {WDOG_BITS{wdog_kick}};
    assign wdog_exp    = 1'b0;
`endif

    assign req       = btn_q | sw_rst_req | wdog_exp;
    assign req_cause = wdog_exp ? 2'b11 : (btn_q ? 2'b01 : 2'b10);
    assign hold_last = (hold_cnt_q == HoldW'(HOLD_CYCLES - 1));
    assign gap_last  = (gap_cnt_q == GapW'(STAGE_GAP - 1));

    // Next release pattern: shift a one in at stage 0.
    always_comb begin
        stage_shift    = stage_q;
        stage_shift[0] = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) begin
            stage_shift[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stage_q    <= '0;
            done_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            stage_q    <= stage_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHold: begin
                if (!req && hold_last) begin
                    state_d = stage_shift[NUM_STAGES-1] ? StRun : StRelease;
                end
            end
            StRelease: begin
                if (req) begin
                    state_d = StHold;
                end else if (gap_last && stage_shift[NUM_STAGES-1]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (req) begin
                    state_d = StHold;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        stage_d    = stage_q;
        done_d     = done_q;
        cause_d    = req ? req_cause : cause_q;
        unique case (state_q)
            StHold: begin
                stage_d   = '0;
                done_d    = 1'b0;
                gap_cnt_d = '0;
                if (req) begin
                    hold_cnt_d = '0;
                end else if (hold_last) begin
                    hold_cnt_d = '0;
                    stage_d    = stage_shift;
                    done_d     = stage_shift[NUM_STAGES-1];
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (req) begin
                    stage_d    = '0;
                    done_d     = 1'b0;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                end else if (gap_last) begin
                    gap_cnt_d = '0;
                    stage_d   = stage_shift;
                    done_d    = stage_shift[NUM_STAGES-1];
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (req) begin
                    stage_d    = '0;
                    done_d     = 1'b0;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            default: begin
                stage_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign stage_rst_n = stage_q;
    assign seq_done    = done_q;
    assign rst_cause   = cause_q;

endmodule
